// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode with valid/ready on both sides.
// Optional zero-latency empty-queue bypass is enabled by defining FDQ_BYPASS_EN.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc_plus1,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc_plus1,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]    instr_mem_q [DEPTH];
  logic [31:0]    pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             overflow_q, overflow_d;

  logic head_valid;
  logic bypass;
  logic push;
  logic pop;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_valid = (count_q != '0);
    in_ready   = (count_q != FULL_CNT);
    bypass     = 1'b0;
`ifdef FDQ_BYPASS_EN
    bypass     = !head_valid && in_valid && !flush;
`endif
    out_valid    = (head_valid || bypass) && !flush;
    out_instr    = '0;
    out_pc_plus1 = '0;
    if (bypass) begin
      out_instr    = in_instr;
      out_pc_plus1 = in_pc_plus1;
    end else if (head_valid) begin
      out_instr    = instr_mem_q[rd_ptr_q];
      out_pc_plus1 = pc_mem_q[rd_ptr_q];
    end

    // A bypassed word that decode takes right away never touches storage.
    push = in_valid && in_ready && !flush && !(bypass && out_ready);
    pop  = head_valid && out_ready && !flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    overflow_d = overflow_q | (in_valid & ~in_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; empty-queue outputs are forced to zero, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc_plus1;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: a queue-based reference model, directed
// scenarios (fill/drain, concurrent push/pop, flush, overflow, reset) and random traffic.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc_plus1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus1;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  bit ovf_m = 1'b0;
  bit mon_en = 1'b0;

  fetch_decode_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc_plus1(in_pc_plus1), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus1(out_pc_plus1), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the model mid-cycle and retires consumed entries.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      int  sz;
      bit  byp;
      bit  exp_v;
      sz    = exp_q.size();
      byp   = BYP && (sz == 0) && in_valid && !flush;
      exp_v = ((sz != 0) || byp) && !flush;
      check("out_valid", 64'(out_valid), 64'(exp_v));
      check("count", 64'(count), 64'(sz));
      check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
      check("overflow", 64'(overflow), 64'(ovf_m));
      if (exp_v && sz != 0) begin
        check("head_data", {out_instr, out_pc_plus1}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end else if (byp) begin
        check("bypass_data", {out_instr, out_pc_plus1}, {in_instr, in_pc_plus1});
      end else if (sz == 0) begin
        check("empty_data", {out_instr, out_pc_plus1}, 64'h0);
      end
    end
  end

  // One clock cycle of stimulus; called just after a rising edge, returns just after the next.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit acc;
    bit ovf_set;
    int sz;
    #1;
    in_valid = v; in_instr = ins; in_pc_plus1 = pc; out_ready = ordy; flush = fl;
    sz      = exp_q.size();
    acc     = v && !fl && (sz != DEPTH) && !(BYP && sz == 0 && ordy);
    ovf_set = v && !fl && (sz == DEPTH);
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back({ins, pc});
    if (ovf_set) ovf_m = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc_plus1 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_instr", 64'(out_instr), 64'h0);
    check("rst_out_pc", 64'(out_pc_plus1), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 32'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Steady concurrent push and pop at count 2.
    step(1'b1, 32'h100, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h101, 32'h12, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 32'h20 + 32'(i), 1'b1, 1'b0);

    // Flush at count 3 drops the queue and the word presented that cycle.
    step(1'b1, 32'h300, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'hBB, 32'hBC, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty queue, word offered while decode is ready (bypass when enabled).
    step(1'b1, 32'h13, 32'h14, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Overflow on a full queue, sticky afterwards.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(i), 32'h40 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h4FF, 32'h4F, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with three entries held.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'h0);
    check("async_rst_out_valid", 64'(out_valid), 64'h0);
    check("async_rst_in_ready", 64'(in_ready), 64'h1);
    check("async_rst_overflow", 64'(overflow), 64'h0);
    exp_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);

    // Random traffic: pointer wrap, mixed stalls, occasional flushes and overflows.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
